// File: rtl/lshift_arbiter.sv
// Round-robin arbiter sharing one combinational left shifter between two requesters,
// with a single registered result stage and saturating per-requester grant counters.
module lshift_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned SW = 6,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_data,
    input  logic [SW-1:0] req0_shamt,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_data,
    input  logic [SW-1:0] req1_shamt,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic [CW-1:0] grant_cnt0,
    output logic [CW-1:0] grant_cnt1
);

    logic          r_out_valid;
    logic          r_out_owner;
    logic [DW-1:0] r_out_data;
    logic          r_prio;
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;

    logic          w_drain;
    logic          w_can_accept;
    logic          w_gnt_valid;
    logic          w_gnt;
    logic          w_accept;
    logic [DW-1:0] w_sel_data;
    logic [SW-1:0] w_sel_shamt;
    logic [DW-1:0] w_shifted;

    always_comb begin
        w_drain      = r_out_valid && (r_out_owner ? rsp1_ready : rsp0_ready);
        w_can_accept = !r_out_valid || w_drain;
        w_gnt_valid  = req0_valid || req1_valid;
        // On a tie the priority bit picks; otherwise whichever side is valid wins.
        w_gnt        = (req0_valid && req1_valid) ? r_prio : req1_valid;
        w_accept     = w_gnt_valid && w_can_accept;
        req0_ready   = w_accept && !w_gnt;
        req1_ready   = w_accept && w_gnt;
    end

    always_comb begin
        w_sel_data  = w_gnt ? req1_data : req0_data;
        w_sel_shamt = w_gnt ? req1_shamt : req0_shamt;
        w_shifted   = '0;
        if (32'(w_sel_shamt) < DW) begin
            w_shifted = w_sel_data << w_sel_shamt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_owner <= 1'b0;
            r_out_data  <= '0;
            r_prio      <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_owner <= w_gnt;
            r_out_data  <= w_shifted;
            r_prio      <= ~w_gnt;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept) begin
            if (!w_gnt && (r_cnt0 != '1)) begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (w_gnt && (r_cnt1 != '1)) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end

    assign rsp0_valid = r_out_valid && !r_out_owner;
    assign rsp1_valid = r_out_valid && r_out_owner;
    assign rsp_data   = r_out_data;
    assign busy       = r_out_valid;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

endmodule
